// File: rtl/xgmii_tx_arbiter_if.sv
// FIFO-read-port bundle between requester FIFOs, the arbiter and the XGMII TX engine.
// master = arbiter side, slave = the FIFO/TX-engine environment side.
interface xgmii_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [72*NUM_REQ-1:0] s_dout;
  logic [NUM_REQ-1:0]    s_empty;
  logic [NUM_REQ-1:0]    s_rd_en;
  logic [71:0]           m_dout;
  logic                  m_empty;
  logic                  m_rd_en;

  modport master (
    input  s_dout, s_empty, m_rd_en,
    output s_rd_en, m_dout, m_empty
  );

  modport slave (
    output s_dout, s_empty, m_rd_en,
    input  s_rd_en, m_dout, m_empty
  );
endinterface

// File: rtl/xgmii_tx_arbiter.sv
// Per-frame round-robin owner of the TX engine FIFO port; grant 1 cycle after eligibility, data muxed combinationally.
// Backpressure is the TX engine's rd_en; a stalled frame is terminated by a watchdog. Stats: XGMII_TX_ARB_STATS_EN.
module xgmii_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                   xgmii_clk,
  input  logic                   sys_rst_n,
  xgmii_tx_arbiter_if.master     bus,
  input  logic [NUM_REQ-1:0]     req_mask,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [32*NUM_REQ-1:0]  frame_cnt,
  output logic [31:0]            abort_cnt
);

  localparam int          IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [15:0] TO = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_ABORT,
    ARB_ABORT_FIN
  } state_t;

  state_t             state, state_nxt;
  logic [IW-1:0]      rr_ptr, g_idx, win_idx;
  logic               win_vld;
  logic [NUM_REQ-1:0] eligible;
  logic               rd_q;
  logic               started;
  logic [15:0]        wd;
  logic [71:0]        g_dout;
  logic               g_empty;
  logic               eof;
  int                 idx;

  assign eligible = ~bus.s_empty & req_mask;
  assign g_dout   = bus.s_dout[72*g_idx +: 72];
  assign g_empty  = bus.s_empty[g_idx];
  assign busy     = (state != ARB_IDLE);

  // Scan downward so the requester closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ARB_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.s_rd_en = '0;
    bus.m_dout  = '0;
    bus.m_empty = 1'b1;
    eof         = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (win_vld) state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        bus.m_dout           = g_dout;
        bus.m_empty          = g_empty;
        bus.s_rd_en[g_idx]   = bus.m_rd_en & ~g_empty;
        eof                  = rd_q && (g_dout[71:64] == 8'h00);
        if (eof)             state_nxt = ARB_IDLE;
        else if (wd == TO)   state_nxt = ARB_ABORT;
      end
      ARB_ABORT: begin
        // Synthetic all-zero terminator offered to the TX engine.
        bus.m_empty = 1'b0;
        if (bus.m_rd_en) state_nxt = ARB_ABORT_FIN;
      end
      ARB_ABORT_FIN: begin
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_q    <= 1'b0;
      grant   <= '0;
      g_idx   <= '0;
      rr_ptr  <= IW'(NUM_REQ - 1);
      wd      <= '0;
      started <= 1'b0;
    end else begin
      rd_q <= bus.m_rd_en & ~bus.m_empty;
      case (state)
        ARB_IDLE: begin
          if (win_vld) begin
            grant   <= NUM_REQ'(1) << win_idx;
            g_idx   <= win_idx;
            rr_ptr  <= win_idx;
          end
          wd      <= '0;
          started <= 1'b0;
        end
        ARB_GRANT: begin
          if (eof) begin
            grant <= '0;
          end else if (rd_q) begin
            wd      <= '0;
            started <= 1'b1;
          end else if (g_empty && started && (wd != TO)) begin
            wd <= wd + 16'd1;
          end
        end
        ARB_ABORT_FIN: begin
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef XGMII_TX_ARB_STATS_EN
  logic [31:0] fc_r [NUM_REQ];
  logic [31:0] ac_r;

  always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) fc_r[i] <= '0;
      ac_r <= '0;
    end else begin
      if (eof)                      fc_r[g_idx] <= fc_r[g_idx] + 32'd1;
      if (state == ARB_ABORT_FIN)   ac_r        <= ac_r + 32'd1;
    end
  end

  always_comb begin
    frame_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) frame_cnt[32*i +: 32] = fc_r[i];
  end

  assign abort_cnt = ac_r;
`else
  assign frame_cnt = '0;
  assign abort_cnt = '0;
`endif

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Directed bench: FIFO and TX-engine models around xgmii_tx_arbiter, hand-computed expectations.
module tb_xgmii_tx_arbiter;
  localparam int NR = 2;
  localparam int TO = 16;
`ifdef XGMII_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        xgmii_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  req_mask  = 2'b11;
  logic [1:0]  grant;
  logic        busy;
  logic [63:0] frame_cnt;
  logic [31:0] abort_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_fc [NR];
  int exp_ac;

  always #5 xgmii_clk = ~xgmii_clk;

  xgmii_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  xgmii_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .xgmii_clk (xgmii_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus.master),
    .req_mask  (req_mask),
    .grant     (grant),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .abort_cnt (abort_cnt)
  );

  // Requester FIFO models: standard FIFO, dout registered one cycle after rd_en.
  logic [71:0] mem [NR][32];
  int          wp [NR];
  int          rp [NR];
  logic [71:0] dout_r [NR] = '{default: '0};
  bit          flush = 1'b0;

  always @(posedge xgmii_clk) begin
    for (int i = 0; i < NR; i++) begin
      if (flush) rp[i] <= wp[i];
      else if (bus.s_rd_en[i]) begin
        dout_r[i] <= mem[i][rp[i] % 32];
        rp[i]     <= rp[i] + 1;
      end
    end
  end

  assign bus.s_dout  = {dout_r[1], dout_r[0]};
  assign bus.s_empty = {wp[1] == rp[1], wp[0] == rp[0]};

  function automatic logic [71:0] fw(input int r, input int fr, input int j, input int n);
    return {(j == n - 1) ? 8'h00 : 8'hff, 8'(r), 8'(fr), 8'(j), 40'h0};
  endfunction

  function automatic logic [63:0] fc_exp();
    logic [31:0] a, b;
    a = exp_fc[0];
    b = exp_fc[1];
    return STATS ? {b, a} : 64'h0;
  endfunction

  function automatic logic [31:0] ac_exp();
    return STATS ? 32'(exp_ac) : 32'h0;
  endfunction

  task automatic push_word(input int r, input logic [71:0] w);
    mem[r][wp[r] % 32] = w;
    wp[r] = wp[r] + 1;
  endtask

  task automatic push_frame(input int r, input int fr, input int n);
    for (int j = 0; j < n; j++) push_word(r, fw(r, fr, j, n));
  endtask

  // TX engine model: one rd_en pulse per word once m_empty is seen low.
  task automatic read_word(output logic [71:0] d, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge xgmii_clk);
      if (bus.m_empty === 1'b0) ok = 1'b1;
    end
    d = 'x;
    if (ok) begin
      bus.m_rd_en = 1'b1;
      @(posedge xgmii_clk);
      #1;
      bus.m_rd_en = 1'b0;
      d = bus.m_dout;
    end
  endtask

  task automatic read_frame(input int r, input int fr, input int n, input string nm);
    logic [71:0] d;
    bit ok;
    for (int j = 0; j < n; j++) begin
      read_word(d, ok);
      checks++;
      if (!ok || d !== fw(r, fr, j, n) || grant !== 2'(1 << r)) begin
        failures++;
        $display("FAIL %s word%0d: got %h grant=%b ok=%0d, expected %h grant=%b",
                 nm, j, d, grant, ok, fw(r, fr, j, n), 2'(1 << r));
      end
    end
    @(negedge xgmii_clk);
    @(negedge xgmii_clk);
    checks++;
    if (grant !== 2'b00) begin
      failures++;
      $display("FAIL %s idle_gap: grant=%b expected 00", nm, grant);
    end
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string nm);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge xgmii_clk);
      if (grant !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (grant !== exp) begin
      failures++;
      $display("FAIL %s grant: got %b expected %b", nm, grant, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge xgmii_clk);
    sys_rst_n = 1'b0;
    flush     = 1'b1;
    @(posedge xgmii_clk);
    #1 flush  = 1'b0;
    @(negedge xgmii_clk);
    sys_rst_n = 1'b1;
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    exp_ac    = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge xgmii_clk);
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || bus.s_rd_en !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctl: grant=%b busy=%b s_rd_en=%b expected 00 0 00", grant, busy, bus.s_rd_en);
    end
    checks++;
    if (bus.m_empty !== 1'b1 || bus.m_dout !== 72'h0) begin
      failures++;
      $display("FAIL reset_out: m_empty=%b m_dout=%h expected 1 0", bus.m_empty, bus.m_dout);
    end
    checks++;
    if (frame_cnt !== 64'h0 || abort_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_cnt: frame_cnt=%h abort_cnt=%h expected 0 0", frame_cnt, abort_cnt);
    end
    @(negedge xgmii_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    @(negedge xgmii_clk);
    push_frame(0, 1, 3);
    #1;
    checks++;
    if (grant !== 2'b00) begin
      failures++;
      $display("FAIL single_pre_grant: grant=%b expected 00", grant);
    end
    @(negedge xgmii_clk);
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: grant=%b busy=%b expected 01 1", grant, busy);
    end
    read_frame(0, 1, 3, "single");
    exp_fc[0]++;
    checks++;
    if (frame_cnt !== fc_exp()) begin
      failures++;
      $display("FAIL single_cnt: frame_cnt=%h expected %h", frame_cnt, fc_exp());
    end
  endtask

  task automatic test_round_robin();
    int order_r [4] = '{0, 1, 0, 1};
    int order_f [4] = '{10, 20, 11, 21};
    @(negedge xgmii_clk);
    push_frame(0, 10, 2);
    push_frame(0, 11, 2);
    push_frame(1, 20, 2);
    push_frame(1, 21, 2);
    for (int k = 0; k < 4; k++) begin
      wait_grant(2'(1 << order_r[k]), "rr");
      read_frame(order_r[k], order_f[k], 2, "rr");
      exp_fc[order_r[k]]++;
    end
    checks++;
    if (frame_cnt !== fc_exp() || abort_cnt !== 32'h0) begin
      failures++;
      $display("FAIL rr_cnt: frame_cnt=%h abort_cnt=%h expected %h 0", frame_cnt, abort_cnt, fc_exp());
    end
  endtask

  task automatic test_watchdog_abort();
    logic [71:0] d;
    bit ok;
    int n;
    @(negedge xgmii_clk);
    push_word(1, fw(1, 30, 0, 2));
    wait_grant(2'b10, "abort");
    push_frame(0, 31, 2);
    read_word(d, ok);
    checks++;
    if (!ok || d !== fw(1, 30, 0, 2)) begin
      failures++;
      $display("FAIL abort_first_word: got %h expected %h", d, fw(1, 30, 0, 2));
    end
    n = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge xgmii_clk);
      #1;
      n++;
      if (bus.m_empty === 1'b0) break;
    end
    checks++;
    if (n !== TO + 2 || grant !== 2'b10 || bus.m_dout !== 72'h0) begin
      failures++;
      $display("FAIL abort_timing: cycles=%0d grant=%b m_dout=%h expected %0d 10 0", n, grant, bus.m_dout, TO + 2);
    end
    read_word(d, ok);
    checks++;
    if (!ok || d !== 72'h0 || bus.s_rd_en !== 2'b00) begin
      failures++;
      $display("FAIL abort_term: got %h s_rd_en=%b expected 0 00", d, bus.s_rd_en);
    end
    @(posedge xgmii_clk);
    #1;
    exp_ac++;
    checks++;
    if (abort_cnt !== ac_exp() || grant !== 2'b00) begin
      failures++;
      $display("FAIL abort_cnt: abort_cnt=%h grant=%b expected %h 00", abort_cnt, grant, ac_exp());
    end
    wait_grant(2'b01, "abort_next");
    read_frame(0, 31, 2, "abort_next");
    exp_fc[0]++;
  endtask

  task automatic test_mask();
    logic [71:0] d;
    bit ok;
    @(negedge xgmii_clk);
    req_mask = 2'b01;
    push_frame(1, 40, 2);
    repeat (5) @(negedge xgmii_clk);
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mask_block: grant=%b busy=%b expected 00 0", grant, busy);
    end
    push_frame(0, 41, 3);
    wait_grant(2'b01, "mask_req0");
    for (int j = 0; j < 3; j++) begin
      read_word(d, ok);
      if (j == 0) req_mask = 2'b00;
      checks++;
      if (!ok || d !== fw(0, 41, j, 3)) begin
        failures++;
        $display("FAIL mask_drop word%0d: got %h expected %h", j, d, fw(0, 41, j, 3));
      end
    end
    exp_fc[0]++;
    repeat (4) @(negedge xgmii_clk);
    checks++;
    if (grant !== 2'b00 || frame_cnt !== fc_exp()) begin
      failures++;
      $display("FAIL mask_done: grant=%b frame_cnt=%h expected 00 %h", grant, frame_cnt, fc_exp());
    end
    req_mask = 2'b11;
    wait_grant(2'b10, "mask_req1");
    read_frame(1, 40, 2, "mask_req1");
    exp_fc[1]++;
  endtask

  task automatic test_reset_mid_frame();
    logic [71:0] d;
    bit ok;
    @(negedge xgmii_clk);
    push_frame(1, 50, 3);
    wait_grant(2'b10, "rst_mid");
    read_word(d, ok);
    checks++;
    if (!ok || d !== fw(1, 50, 0, 3)) begin
      failures++;
      $display("FAIL rst_mid_word: got %h expected %h", d, fw(1, 50, 0, 3));
    end
    @(negedge xgmii_clk);
    bus.m_rd_en = 1'b1;
    sys_rst_n   = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || bus.s_rd_en !== 2'b00 || bus.m_empty !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: grant=%b s_rd_en=%b m_empty=%b busy=%b expected 00 00 1 0",
               grant, bus.s_rd_en, bus.m_empty, busy);
    end
    checks++;
    if (frame_cnt !== 64'h0 || abort_cnt !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_cnt: frame_cnt=%h abort_cnt=%h expected 0 0", frame_cnt, abort_cnt);
    end
    bus.m_rd_en = 1'b0;
    flush       = 1'b1;
    @(posedge xgmii_clk);
    #1 flush    = 1'b0;
    @(negedge xgmii_clk);
    sys_rst_n = 1'b1;
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    exp_ac    = 0;
    push_frame(0, 60, 2);
    push_frame(1, 61, 2);
    wait_grant(2'b01, "rst_after0");
    read_frame(0, 60, 2, "rst_after0");
    exp_fc[0]++;
    wait_grant(2'b10, "rst_after1");
    read_frame(1, 61, 2, "rst_after1");
    exp_fc[1]++;
    checks++;
    if (frame_cnt !== fc_exp()) begin
      failures++;
      $display("FAIL rst_after_cnt: frame_cnt=%h expected %h", frame_cnt, fc_exp());
    end
  endtask

  initial begin
    bus.m_rd_en = 1'b0;
    exp_fc[0]   = 0;
    exp_fc[1]   = 0;
    exp_ac      = 0;
    test_reset();
    test_single_frame();
    apply_reset();
    test_round_robin();
    test_watchdog_abort();
    test_mask();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
